mem_access_stage: RTL and testbench

- Pipeline MEM stage of the 64-bit LEGv8-style CPU.
- Consumes the 232-bit EX/MEM buffer and performs the data-memory load or store.
- Resolves the branch decision (PCSrc) and produces writeback data, destination register and RegWrite for the WB stage.
- Also contains the combinational ALU-control decoder (opcode + ALUOp -> 4-bit ALU operation) that the EX stage uses.

---
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of the 64-bit LEGv8-style pipeline. Takes the EX/MEM buffer,
//   performs the data-memory load/store, resolves the branch decision and
//   registers the writeback bundle for WB. Also hosts the combinational
//   ALU-control decoder used by EX.
//
// Ports:
//   clk          stage clock, all state updates on the rising edge
//   rst          synchronous active-high reset (clears outputs and memory)
//   in_buf       232-bit EX/MEM buffer
//                  [31:0] instruction, [95:32] branch target,
//                  [159:96] ALU result, [223:160] store data,
//                  [224] zero, [225] B, [226] BZ, [227] BNZ, [228] MemRead,
//                  [229] MemWrite, [230] MemtoReg, [231] RegWrite
//   branch_addr  registered branch target
//   pc_src       registered branch-taken decision
//   reg_write    registered RegWrite for WB
//   wr_data      registered writeback data
//   wr_reg       registered destination register (instruction[4:0])
//   opcode       instruction[31:21] for ALU control
//   alu_op       ALUOp from the main control unit
//   alu_ctrl     decoded 4-bit ALU operation (combinational)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [231:0] in_buf,
  output logic [63:0]  branch_addr,
  output logic         pc_src,
  output logic         reg_write,
  output logic [63:0]  wr_data,
  output logic [4:0]   wr_reg,
  input  logic [10:0]  opcode,
  input  logic [1:0]   alu_op,
  output logic [3:0]   alu_ctrl
);

  // ALU operation encodings
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_BAD   = 4'b1111;

  // Field views of the EX/MEM buffer
  logic [31:0] instruction;
  logic [63:0] branchTarget;
  logic [63:0] aluResult;
  logic [63:0] storeData;
  logic        zeroFlag;
  logic        uncondBranch;
  logic        branchZero;
  logic        branchNotZero;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        regWriteIn;

  assign instruction   = in_buf[31:0];
  assign branchTarget  = in_buf[95:32];
  assign aluResult     = in_buf[159:96];
  assign storeData     = in_buf[223:160];
  assign zeroFlag      = in_buf[224];
  assign uncondBranch  = in_buf[225];
  assign branchZero    = in_buf[226];
  assign branchNotZero = in_buf[227];
  assign memRead       = in_buf[228];
  assign memWrite      = in_buf[229];
  assign memToReg      = in_buf[230];
  assign regWriteIn    = in_buf[231];

  // Address bits below the doubleword and above the index are deliberately
  // dropped, so they are gathered here to show they are intentionally unused.
  logic unusedBits;
  assign unusedBits = ^{instruction[31:5], aluResult[63:AW+3], aluResult[2:0]};

  // Data memory and registered stage outputs
  logic [63:0] mem_q [DEPTH];
  logic [63:0] branch_addr_q, branch_addr_d;
  logic        pc_src_q, pc_src_d;
  logic        reg_write_q, reg_write_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic [4:0]  wr_reg_q, wr_reg_d;

  logic [AW-1:0] memIdx;
  logic [63:0]   readData;

  // Next-state for the writeback bundle. The load reads the array before the
  // edge commits any store, which gives read-old-data when a bundle both
  // reads and writes the same doubleword.
  always_comb begin
    memIdx        = aluResult[AW+2:3];
    readData      = memRead ? mem_q[memIdx] : 64'd0;
    wr_data_d     = memToReg ? readData : aluResult;
    wr_reg_d      = instruction[4:0];
    reg_write_d   = regWriteIn;
    branch_addr_d = branchTarget;
    pc_src_d      = uncondBranch | (branchZero & zeroFlag) | (branchNotZero & ~zeroFlag);
  end

  // Register the bundle and commit stores. Reset wins over whatever is on
  // in_buf, clears every memory word and suppresses the store.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_addr_q <= '0;
      pc_src_q      <= 1'b0;
      reg_write_q   <= 1'b0;
      wr_data_q     <= '0;
      wr_reg_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      branch_addr_q <= branch_addr_d;
      pc_src_q      <= pc_src_d;
      reg_write_q   <= reg_write_d;
      wr_data_q     <= wr_data_d;
      wr_reg_q      <= wr_reg_d;
      if (memWrite) begin
        mem_q[memIdx] <= storeData;
      end
    end
  end

  assign branch_addr = branch_addr_q;
  assign pc_src      = pc_src_q;
  assign reg_write   = reg_write_q;
  assign wr_data     = wr_data_q;
  assign wr_reg      = wr_reg_q;

  // ALU control decoder. R-type needs the full 11-bit opcode; I-type opcodes
  // are only 10 bits wide so opcode[0] is ignored there. Anything unmatched
  // is flagged as illegal with 1111.
  always_comb begin
    alu_ctrl = ALU_BAD;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_PASSB;
      2'b10: begin
        case (opcode)
          11'b10001011000: alu_ctrl = ALU_ADD;
          11'b11001011000: alu_ctrl = ALU_SUB;
          11'b10001010000: alu_ctrl = ALU_AND;
          11'b10101010000: alu_ctrl = ALU_ORR;
          default:         alu_ctrl = ALU_BAD;
        endcase
      end
      default: begin
        case (opcode[10:1])
          10'b1001000100: alu_ctrl = ALU_ADD;
          10'b1101000100: alu_ctrl = ALU_SUB;
          10'b1001001000: alu_ctrl = ALU_AND;
          10'b1011001000: alu_ctrl = ALU_ORR;
          default:        alu_ctrl = ALU_BAD;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. A behavioural model (plain
//   array memory plus the branch/writeback rules) predicts every registered
//   output; the ALU-control decoder is checked against a lookup table.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int DEPTH = 32;

  logic         clk;
  logic         rst;
  logic [231:0] in_buf;
  logic [63:0]  branch_addr;
  logic         pc_src;
  logic         reg_write;
  logic [63:0]  wr_data;
  logic [4:0]   wr_reg;
  logic [10:0]  opcode;
  logic [1:0]   alu_op;
  logic [3:0]   alu_ctrl;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  logic [63:0] modelMem [DEPTH];
  logic [63:0] expBranchAddr;
  logic        expPcSrc;
  logic        expRegWrite;
  logic [63:0] expWrData;
  logic [4:0]  expWrReg;

  mem_access_stage #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_buf     (in_buf),
    .branch_addr(branch_addr),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wr_data    (wr_data),
    .wr_reg     (wr_reg),
    .opcode     (opcode),
    .alu_op     (alu_op),
    .alu_ctrl   (alu_ctrl)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pack an EX/MEM bundle from its fields
  function automatic logic [231:0] makeBuf(
      input logic [31:0] instr, input logic [63:0] target,
      input logic [63:0] result, input logic [63:0] data,
      input logic zero, input logic b, input logic bz, input logic bnz,
      input logic mr, input logic mw, input logic m2r, input logic rw);
    return {rw, m2r, mw, mr, bnz, bz, b, zero, data, result, target, instr};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Advance the model by one edge using the architectural rules
  task automatic modelStep(input logic [231:0] b, input logic r);
    logic [63:0] result;
    logic [63:0] loaded;
    int          idx;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) modelMem[i] = 64'd0;
      expBranchAddr = 64'd0;
      expPcSrc      = 1'b0;
      expRegWrite   = 1'b0;
      expWrData     = 64'd0;
      expWrReg      = 5'd0;
    end else begin
      result        = b[159:96];
      idx           = int'((result / 8) % DEPTH);
      loaded        = b[228] ? modelMem[idx] : 64'd0;
      expWrData     = b[230] ? loaded : result;
      expWrReg      = b[4:0];
      expRegWrite   = b[231];
      expBranchAddr = b[95:32];
      expPcSrc      = b[225] || (b[226] && b[224]) || (b[227] && !b[224]);
      if (b[229]) modelMem[idx] = b[223:160];
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".branch_addr"}, branch_addr, expBranchAddr);
    checkOutput({tag, ".pc_src"}, {63'd0, pc_src}, {63'd0, expPcSrc});
    checkOutput({tag, ".reg_write"}, {63'd0, reg_write}, {63'd0, expRegWrite});
    checkOutput({tag, ".wr_data"}, wr_data, expWrData);
    checkOutput({tag, ".wr_reg"}, {59'd0, wr_reg}, {59'd0, expWrReg});
  endtask

  // Drive one bundle at the falling edge, clock it in, then compare the
  // registered outputs shortly after the rising edge
  task automatic applyStimulus(input logic [231:0] b, input logic r, input string tag);
    @(negedge clk);
    in_buf = b;
    rst    = r;
    @(posedge clk);
    modelStep(b, r);
    #1;
    compareAll(tag);
  endtask

  // ALU-control reference as lookup tables
  function automatic logic [3:0] refAluCtrl(input logic [1:0] op, input logic [10:0] opc);
    logic [10:0] rOpc [4];
    logic [9:0]  iOpc [4];
    logic [3:0]  ctl  [4];
    rOpc = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    iOpc = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    ctl  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0111;
    for (int i = 0; i < 4; i++) begin
      if (op == 2'b10 && opc == rOpc[i]) return ctl[i];
      if (op == 2'b11 && opc[10:1] == iOpc[i]) return ctl[i];
    end
    return 4'b1111;
  endfunction

  task automatic checkAlu(input logic [1:0] op, input logic [10:0] opc,
                          input logic [3:0] want, input string tag);
    alu_op = op;
    opcode = opc;
    #1;
    checkOutput(tag, {60'd0, alu_ctrl}, {60'd0, want});
  endtask

  logic [231:0] b;
  logic [63:0]  storedWord;
  logic [63:0]  resetAddr;

  initial begin
    rst    = 1'b1;
    in_buf = '0;
    opcode = '0;
    alu_op = '0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 64'd0;

    // Reset with random bundles present
    applyStimulus({rand64(), rand64(), rand64(), rand64()}, 1'b1, "reset0");
    applyStimulus({rand64(), rand64(), rand64(), rand64()}, 1'b1, "reset1");
    checkOutput("reset.wr_data_zero", wr_data, 64'd0);
    applyStimulus(makeBuf(32'd0, 64'd0, 64'h40, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "clearedLoad");
    checkOutput("cleared_load", wr_data, 64'd0);

    // Store then load, including a wrapped address
    applyStimulus(makeBuf(32'd0, 64'd0, 64'h18, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, "store");
    applyStimulus(makeBuf(32'd9, 64'd0, 64'h18, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "load");
    checkOutput("load_data", wr_data, 64'hDEADBEEF_CAFEF00D);
    checkOutput("load_reg", {59'd0, wr_reg}, 64'd9);
    checkOutput("load_rw", {63'd0, reg_write}, 64'd1);
    applyStimulus(makeBuf(32'd9, 64'd0, 64'h118, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "wrapLoad");
    checkOutput("wrap_load_data", wr_data, 64'hDEADBEEF_CAFEF00D);

    // ALU result passthrough, then read-old-data on a same-edge store
    applyStimulus(makeBuf(32'd3, 64'd0, 64'h1234, 64'd0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, "rtype");
    checkOutput("rtype_data", wr_data, 64'h1234);
    applyStimulus(makeBuf(32'd4, 64'd0, 64'h18, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 1, 1, 1, 1), 1'b0, "rdwr");
    checkOutput("rdwr_old", wr_data, 64'hDEADBEEF_CAFEF00D);
    applyStimulus(makeBuf(32'd4, 64'd0, 64'h18, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "rdwrNext");
    checkOutput("rdwr_new", wr_data, 64'h1111_2222_3333_4444);

    // Branch decisions with target 0x1000
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "brB");
    checkOutput("br_b", {63'd0, pc_src}, 64'd1);
    checkOutput("br_addr", branch_addr, 64'h1000);
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0, "brBzTaken");
    checkOutput("br_bz_z1", {63'd0, pc_src}, 64'd1);
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "brBzNot");
    checkOutput("br_bz_z0", {63'd0, pc_src}, 64'd0);
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, "brBnzTaken");
    checkOutput("br_bnz_z0", {63'd0, pc_src}, 64'd1);
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 1, 0, 0, 1, 0, 0, 0, 0), 1'b0, "brBnzNot");
    checkOutput("br_bnz_z1", {63'd0, pc_src}, 64'd0);
    applyStimulus(makeBuf(32'd0, 64'h1000, 64'd0, 64'd0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "brNone");
    checkOutput("br_none", {63'd0, pc_src}, 64'd0);

    // ALU control sweep
    checkAlu(2'b00, 11'($urandom()), 4'b0010, "alu_00");
    checkAlu(2'b01, 11'($urandom()), 4'b0111, "alu_01");
    checkAlu(2'b10, 11'b11001011000, 4'b0110, "alu_sub");
    checkAlu(2'b10, 11'b10101010000, 4'b0001, "alu_orr");
    checkAlu(2'b10, 11'b10001011000, 4'b0010, "alu_add");
    checkAlu(2'b10, 11'b10001010000, 4'b0000, "alu_and");
    checkAlu(2'b11, 11'b10010010001, 4'b0000, "alu_andi");
    checkAlu(2'b11, 11'b11010001000, 4'b0110, "alu_subi");
    checkAlu(2'b11, 11'b10010001001, 4'b0010, "alu_addi");
    checkAlu(2'b11, 11'b10110010000, 4'b0001, "alu_orri");
    checkAlu(2'b10, 11'b11111111111, 4'b1111, "alu_bad_r");
    checkAlu(2'b10, 11'b10001011001, 4'b1111, "alu_r_lsb");
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [10:0] opc;
      op  = 2'($urandom());
      opc = 11'($urandom());
      checkAlu(op, opc, refAluCtrl(op, opc), "alu_rand");
    end

    // Mid-stream reset: store, then reset while a store bundle is presented
    storedWord = rand64();
    applyStimulus(makeBuf(32'd0, 64'd0, 64'h50, storedWord, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, "preResetStore");
    resetAddr = rand64();
    applyStimulus(makeBuf(32'd7, rand64(), resetAddr, rand64(), 1, 1, 1, 1, 1, 1, 1, 1), 1'b1, "midReset");
    checkOutput("mid_reset_data", wr_data, 64'd0);
    checkOutput("mid_reset_pc", {63'd0, pc_src}, 64'd0);
    applyStimulus(makeBuf(32'd1, 64'd0, 64'h50, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "postResetLoad");
    checkOutput("post_reset_word", wr_data, 64'd0);
    applyStimulus(makeBuf(32'd1, 64'd0, resetAddr, 64'd0, 0, 0, 0, 0, 1, 0, 1, 1), 1'b0, "resetBundleLoad");
    checkOutput("reset_bundle_word", wr_data, 64'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [63:0] res;
      res = rand64();
      if ($urandom_range(0, 3) != 0) res[63:8] = '0;
      b = makeBuf($urandom(), rand64(), res, rand64(),
                  1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                  1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
      applyStimulus(b, ($urandom_range(0, 49) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
